// File: rtl/yd_pkg.sv
// Shared definitions for the yd register file: address map constants and
// the context-copy FSM encoding.
// Latency: n/a (definitions only). Backpressure: n/a.
// Contents: ADDR_* constants, pc_addr() helper, ctx_state_e.
package yd_pkg;

   // Fixed low addresses; GPRs start at ADDR_GPR_BASE and end just below PC.
   localparam int ADDR_ZERO     = 0;
   localparam int ADDR_DK       = 1;
   localparam int ADDR_GPR_BASE = 2;

   // PC always lives at the top of the address space.
   function automatic int pc_addr(input int aw);
      return (1 << aw) - 1;
   endfunction

   typedef enum logic [1:0] {
      CTX_IDLE    = 2'd0,
      CTX_SAVE    = 2'd1,
      CTX_RESTORE = 2'd2
   } ctx_state_e;

endpackage

// File: rtl/yd_wr_arb.sv
// Write-port arbiter: folds NW write ports into one enable/data per register.
// Latency: combinational. Backpressure: none; lowest port index wins a clash.
// Ports: we_i/waddr_i/wdata_i (packed, port 0 at LSBs) -> reg_we_o/reg_wdata_o
// indexed by register address (1..NREG-1; address 0 is never written).
module yd_wr_arb
   import yd_pkg::*;
#(
   parameter int DW = 16,
   parameter int AW = 4,
   parameter int NW = 2,
   localparam int NREG = 1 << AW
) (
   input  logic [NW-1:0]               we_i,
   input  logic [NW*AW-1:0]            waddr_i,
   input  logic [NW*DW-1:0]            wdata_i,
   output logic [NREG-1:1]             reg_we_o,
   output logic [NREG-1:1][DW-1:0]     reg_wdata_o
);

   // Walk ports from highest to lowest so a lower port overwrites a higher
   // one targeting the same register.
   always_comb begin
      reg_we_o    = '0;
      reg_wdata_o = '0;
      for (int p = NW - 1; p >= 0; p--) begin
         if (we_i[p] && (waddr_i[p*AW +: AW] != AW'(ADDR_ZERO))) begin
            reg_we_o[waddr_i[p*AW +: AW]]    = 1'b1;
            reg_wdata_o[waddr_i[p*AW +: AW]] = wdata_i[p*DW +: DW];
         end
      end
   end

endmodule

// File: rtl/yd_regfile_p.sv
// Multi-ported register file with ZERO/DK/GPR/PC map and a shadow GPR bank.
// Latency: read data one cycle after raddr (write-first); copies take 2^AW-3 cycles.
// Backpressure: none; ctx requests and GPR writes are dropped while ctx_busy.
// Ports: clk/rst, pc_hold, we/waddr/wdata (NW ports), raddr/rdata (NR ports),
// ctx_save/ctx_restore/ctx_busy, pc_out.
module yd_regfile_p
   import yd_pkg::*;
#(
   parameter int DW = 16,
   parameter int AW = 4,
   parameter int NR = 2,
   parameter int NW = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pc_hold,
   input  logic [NW-1:0]     we,
   input  logic [NW*AW-1:0]  waddr,
   input  logic [NW*DW-1:0]  wdata,
   input  logic [NR*AW-1:0]  raddr,
   output logic [NR*DW-1:0]  rdata,
   input  logic              ctx_save,
   input  logic              ctx_restore,
   output logic              ctx_busy,
   output logic [DW-1:0]     pc_out
);

   localparam int NREG     = 1 << AW;
   localparam int PC_IDX   = pc_addr(AW);
   localparam int LAST_GPR = PC_IDX - 1;
   localparam int NGPR     = LAST_GPR - ADDR_GPR_BASE + 1;

   // Register 0 reads as zero and is never stored.
   logic [DW-1:0]             mem_q    [NREG-1:1];
   logic [DW-1:0]             shadow_q [NGPR-1:0];
   logic [NR*AW-1:0]          raddr_q;

   ctx_state_e                state_q, state_d;
   logic [AW-1:0]             cnt_q, cnt_d;
   logic [AW-1:0]             sh_idx;
   logic                      busy;

   logic [NREG-1:1]           reg_we;
   logic [NREG-1:1][DW-1:0]   reg_wdata;

   yd_wr_arb #(
      .DW (DW),
      .AW (AW),
      .NW (NW)
   ) u_wr_arb (
      .we_i        (we),
      .waddr_i     (waddr),
      .wdata_i     (wdata),
      .reg_we_o    (reg_we),
      .reg_wdata_o (reg_wdata)
   );

   assign busy     = (state_q != CTX_IDLE);
   assign ctx_busy = busy;
   assign sh_idx   = cnt_q - AW'(ADDR_GPR_BASE);
   assign pc_out   = mem_q[PC_IDX];

   // Context-copy FSM: cnt walks the GPR addresses, one register per cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CTX_IDLE: begin
            if (ctx_save) begin
               state_d = CTX_SAVE;
               cnt_d   = AW'(ADDR_GPR_BASE);
            end else if (ctx_restore) begin
               state_d = CTX_RESTORE;
               cnt_d   = AW'(ADDR_GPR_BASE);
            end
         end
         CTX_SAVE, CTX_RESTORE: begin
            if (cnt_q == AW'(LAST_GPR)) begin
               state_d = CTX_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = CTX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CTX_IDLE;
         cnt_q   <= '0;
         raddr_q <= '0;
         for (int i = 1; i < NREG; i++) begin
            mem_q[i] <= '0;
         end
         for (int g = 0; g < NGPR; g++) begin
            shadow_q[g] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         raddr_q <= raddr;

         // PC free-runs unless held; only a held PC accepts writes.
         if (!pc_hold) begin
            mem_q[PC_IDX] <= mem_q[PC_IDX] + DW'(1);
         end else if (reg_we[PC_IDX]) begin
            mem_q[PC_IDX] <= reg_wdata[PC_IDX];
         end

         // DK is outside the shadowed set, so it stays writable while busy.
         if (reg_we[ADDR_DK]) begin
            mem_q[ADDR_DK] <= reg_wdata[ADDR_DK];
         end

         for (int i = ADDR_GPR_BASE; i <= LAST_GPR; i++) begin
            if ((state_q == CTX_RESTORE) && (cnt_q == AW'(i))) begin
               mem_q[i] <= shadow_q[i - ADDR_GPR_BASE];
            end else if (!busy && reg_we[i]) begin
               mem_q[i] <= reg_wdata[i];
            end
         end

         if (state_q == CTX_SAVE) begin
            shadow_q[sh_idx] <= mem_q[cnt_q];
         end
      end
   end

   // Reads use the registered address against the already-updated array,
   // which gives write-first behaviour for writes on the sampling edge.
   always_comb begin
      rdata = '0;
      for (int r = 0; r < NR; r++) begin
         if (raddr_q[r*AW +: AW] != AW'(ADDR_ZERO)) begin
            rdata[r*DW +: DW] = mem_q[raddr_q[r*AW +: AW]];
         end
      end
   end

endmodule

// File: tb/tb_yd_regfile_p.sv
// Directed testbench for yd_regfile_p (default parameters DW=16, AW=4, NR=2, NW=2).
module tb_yd_regfile_p;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_hold;
   logic [1:0]  we;
   logic [7:0]  waddr;
   logic [31:0] wdata;
   logic [7:0]  raddr;
   logic [31:0] rdata;
   logic        ctx_save;
   logic        ctx_restore;
   logic        ctx_busy;
   logic [15:0] pc_out;

   int checks = 0;
   int errors = 0;

   yd_regfile_p #(.DW(16), .AW(4), .NR(2), .NW(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_hold     (pc_hold),
      .we          (we),
      .waddr       (waddr),
      .wdata       (wdata),
      .raddr       (raddr),
      .rdata       (rdata),
      .ctx_save    (ctx_save),
      .ctx_restore (ctx_restore),
      .ctx_busy    (ctx_busy),
      .pc_out      (pc_out)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Fill GPRs 2..14 with i*mult, two per cycle.
   task automatic fill(input logic [15:0] mult);
      for (int i = 2; i <= 14; i += 2) begin
         we           = (i + 1 <= 14) ? 2'b11 : 2'b01;
         waddr[3:0]   = 4'(i);
         waddr[7:4]   = 4'(i + 1);
         wdata[15:0]  = 16'(i) * mult;
         wdata[31:16] = 16'(i + 1) * mult;
         tick();
      end
      we = 2'b00;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (ctx_busy && n < 40) begin
         tick();
         n++;
      end
      chk(tag, {15'd0, ctx_busy}, 16'd0);
   endtask

   initial begin
      int busy_cnt;
      rst         = 1'b1;
      pc_hold     = 1'b1;
      we          = 2'b00;
      waddr       = '0;
      wdata       = '0;
      raddr       = '0;
      ctx_save    = 1'b0;
      ctx_restore = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_busy", {15'd0, ctx_busy}, 16'd0);
      chk("rst_pc", pc_out, 16'h0000);
      chk("rst_rdata0", rdata[15:0], 16'h0000);
      raddr = {4'd3, 4'd3};
      tick();
      chk("rst_r3", rdata[31:16], 16'h0000);

      // Write-first: write R3 while reading it
      we = 2'b01; waddr[3:0] = 4'd3; wdata[15:0] = 16'h1234; raddr[3:0] = 4'd3;
      tick();
      chk("wfirst_r3", rdata[15:0], 16'h1234);

      // Same-address clash: port 0 wins
      we = 2'b11; waddr = {4'd5, 4'd5}; wdata = {16'h5555, 16'hAAAA}; raddr = {4'd5, 4'd5};
      tick();
      chk("clash_r5_p0", rdata[15:0], 16'hAAAA);
      chk("clash_r5_p1", rdata[31:16], 16'hAAAA);

      // Writes to ZERO ignored
      we = 2'b01; waddr[3:0] = 4'd0; wdata[15:0] = 16'hFFFF; raddr[3:0] = 4'd0;
      tick();
      chk("zero_read", rdata[15:0], 16'h0000);

      // Two distinct writes in one cycle
      we = 2'b11; waddr = {4'd7, 4'd6}; wdata = {16'h0707, 16'h0606}; raddr = {4'd7, 4'd6};
      tick();
      chk("dual_r6", rdata[15:0], 16'h0606);
      chk("dual_r7", rdata[31:16], 16'h0707);

      // PC: load 0xFFFF while held, wrap on increment, ignore write while running
      we = 2'b10; waddr[7:4] = 4'd15; wdata[31:16] = 16'hFFFF;
      tick();
      chk("pc_load_ffff", pc_out, 16'hFFFF);
      pc_hold = 1'b0; we = 2'b01; waddr[3:0] = 4'd15; wdata[15:0] = 16'h1111;
      tick();
      chk("pc_wrap", pc_out, 16'h0000);
      pc_hold = 1'b1; wdata[15:0] = 16'h0040;
      tick();
      chk("pc_load_40", pc_out, 16'h0040);
      we = 2'b00; raddr[3:0] = 4'd15;
      tick();
      chk("pc_hold", pc_out, 16'h0040);
      chk("pc_read", rdata[15:0], 16'h0040);

      // Context save of i*0x11, with writes and a stray restore during SAVE
      fill(16'h0011);
      ctx_save = 1'b1;
      tick();
      ctx_save = 1'b0;
      busy_cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (ctx_busy) busy_cnt++;
         if (k == 0) begin
            we = 2'b11; waddr = {4'd1, 4'd2}; wdata = {16'h00FF, 16'hDEAD};
         end else begin
            we = 2'b00;
         end
         ctx_restore = (k == 3);
         tick();
      end
      ctx_restore = 1'b0;
      chk("save_busy_cycles", 16'(busy_cnt), 16'd13);
      raddr = {4'd1, 4'd2};
      tick();
      chk("save_r2_dropped", rdata[15:0], 16'h0022);
      chk("save_dk_written", rdata[31:16], 16'h00FF);

      // Overwrite, then restore; R14 read mid-restore is still the new value
      fill(16'h0101);
      raddr = {4'd0, 4'd9};
      tick();
      chk("overwrite_r9", rdata[15:0], 16'h0909);
      ctx_restore = 1'b1;
      tick();
      ctx_restore = 1'b0;
      chk("restore_busy", {15'd0, ctx_busy}, 16'd1);
      raddr[3:0] = 4'd14;
      tick();
      chk("restore_r14_pre", rdata[15:0], 16'h0E0E);
      wait_idle("restore_done");
      for (int i = 2; i <= 14; i += 2) begin
         raddr = {4'(i + 1), 4'(i)};
         tick();
         chk($sformatf("restore_r%0d", i), rdata[15:0], 16'(i) * 16'h0011);
         chk($sformatf("restore_r%0d", i + 1), rdata[31:16],
             (i + 1 == 15) ? 16'h0040 : 16'(i + 1) * 16'h0011);
      end

      // Reset during cycle 5 of RESTORE
      fill(16'h0101);
      ctx_restore = 1'b1;
      tick();
      ctx_restore = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      chk("abort_busy", {15'd0, ctx_busy}, 16'd0);
      rst = 1'b0;
      for (int i = 0; i < 16; i += 2) begin
         raddr = {4'(i + 1), 4'(i)};
         tick();
         chk($sformatf("abort_r%0d", i), rdata[15:0], 16'h0000);
         chk($sformatf("abort_r%0d", i + 1), rdata[31:16], 16'h0000);
      end
      chk("abort_pc", pc_out, 16'h0000);

      // Shadow bank was cleared too: a fresh restore yields zeros
      we = 2'b01; waddr[3:0] = 4'd5; wdata[15:0] = 16'h5A5A;
      tick();
      we = 2'b00;
      ctx_restore = 1'b1;
      tick();
      ctx_restore = 1'b0;
      wait_idle("shadow_restore_done");
      raddr = {4'd0, 4'd5};
      tick();
      chk("shadow_cleared_r5", rdata[15:0], 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
